// File: rtl/mem_wb_arbiter.sv
// Two-master round-robin Wishbone arbiter in front of the on-chip memory slave.
// Master 0 is the CPU data port, master 1 the housekeeping/debug master.
// A grant is held for the whole bus cycle; a watchdog returns err if the slave hangs.
module mem_wb_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned CNT_W          = 8
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic [31:0]       m0_adr_i,
  input  logic [31:0]       m0_dat_i,
  input  logic [3:0]        m0_sel_i,
  input  logic              m0_we_i,
  input  logic              m0_cyc_i,
  input  logic              m0_stb_i,
  output logic              m0_ack_o,
  output logic              m0_err_o,
  output logic [31:0]       m0_dat_o,
  input  logic [31:0]       m1_adr_i,
  input  logic [31:0]       m1_dat_i,
  input  logic [3:0]        m1_sel_i,
  input  logic              m1_we_i,
  input  logic              m1_cyc_i,
  input  logic              m1_stb_i,
  output logic              m1_ack_o,
  output logic              m1_err_o,
  output logic [31:0]       m1_dat_o,
  output logic [31:0]       s_adr_o,
  output logic [31:0]       s_dat_o,
  output logic [3:0]        s_sel_o,
  output logic              s_we_o,
  output logic              s_cyc_o,
  output logic              s_stb_o,
  input  logic              s_ack_i,
  input  logic [31:0]       s_dat_i,
  output logic [1:0]        grant_o
);

  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT0  = 2'd1,
    GRANT1  = 2'd2,
    ERRWAIT = 2'd3
  } state_t;

  state_t           state;
  logic             lg;        // last granted master; also the errored master in ERRWAIT
  logic [CNT_W-1:0] wdog;

  logic sel0;
  logic sel1;
  logic pending;
  logic timeout;

  assign sel0    = (state == GRANT0);
  assign sel1    = (state == GRANT1);
  assign grant_o = {sel1, sel0};

  // Slave port follows the granted master; everything low when nobody owns the bus.
  always_comb begin
    s_adr_o = '0;
    s_dat_o = '0;
    s_sel_o = '0;
    s_we_o  = 1'b0;
    s_cyc_o = 1'b0;
    s_stb_o = 1'b0;
    if (sel0) begin
      s_adr_o = m0_adr_i;
      s_dat_o = m0_dat_i;
      s_sel_o = m0_sel_i;
      s_we_o  = m0_we_i;
      s_cyc_o = m0_cyc_i;
      s_stb_o = m0_stb_i;
    end else if (sel1) begin
      s_adr_o = m1_adr_i;
      s_dat_o = m1_dat_i;
      s_sel_o = m1_sel_i;
      s_we_o  = m1_we_i;
      s_cyc_o = m1_cyc_i;
      s_stb_o = m1_stb_i;
    end
  end

  // A strobe waiting on the slave; an ack in the same cycle always beats the timeout.
  assign pending = s_cyc_o & s_stb_o & ~s_ack_i;
  assign timeout = pending & (wdog == TMO_LAST);

  // Responses only ever reach the owner of the bus; read data is broadcast.
  assign m0_ack_o = sel0 & s_ack_i;
  assign m1_ack_o = sel1 & s_ack_i;
  assign m0_err_o = sel0 & timeout;
  assign m1_err_o = sel1 & timeout;
  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;

  // Arbitration state, round-robin pointer and watchdog counter.
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_i) begin
      state <= IDLE;
      lg    <= 1'b1;
      wdog  <= '0;
    end else begin
      case (state)
        IDLE: begin
          wdog <= '0;
          if (m0_cyc_i && m1_cyc_i) begin
            state <= lg ? GRANT0 : GRANT1;
          end else if (m0_cyc_i) begin
            state <= GRANT0;
          end else if (m1_cyc_i) begin
            state <= GRANT1;
          end
        end
        GRANT0: begin
          if (!m0_cyc_i) begin
            lg    <= 1'b0;
            state <= IDLE;
            wdog  <= '0;
          end else if (timeout) begin
            lg    <= 1'b0;
            state <= ERRWAIT;
            wdog  <= '0;
          end else if (pending) begin
            if (wdog != '1) wdog <= wdog + CNT_W'(1);
          end else begin
            wdog <= '0;
          end
        end
        GRANT1: begin
          if (!m1_cyc_i) begin
            lg    <= 1'b1;
            state <= IDLE;
            wdog  <= '0;
          end else if (timeout) begin
            lg    <= 1'b1;
            state <= ERRWAIT;
            wdog  <= '0;
          end else if (pending) begin
            if (wdog != '1) wdog <= wdog + CNT_W'(1);
          end else begin
            wdog <= '0;
          end
        end
        ERRWAIT: begin
          // Hold off until the hung master abandons its cycle.
          wdog <= '0;
          if (lg ? !m1_cyc_i : !m0_cyc_i) state <= IDLE;
        end
        default: begin
          state <= IDLE;
          wdog  <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_wb_arbiter.sv
// Self-checking bench for mem_wb_arbiter: directed scenarios plus a slave-side scoreboard.
module tb_mem_wb_arbiter;

  localparam logic [31:0] RDATA = 32'h1234_5678;

  typedef struct packed {
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic        we;
  } xfer_t;

  typedef struct packed {
    logic [1:0] g;
    logic       a0;
    logic       a1;
    logic       c0;
  } smp_t;

  logic        clk;
  logic        rst_n;
  logic [31:0] madr [2];
  logic [31:0] mdat [2];
  logic [3:0]  msel [2];
  logic        mwe  [2];
  logic        mcyc [2];
  logic        mstb [2];
  logic        m0_ack, m1_ack, m0_err, m1_err;
  logic [31:0] m0_rdat, m1_rdat;
  logic [31:0] s_adr, s_dat;
  logic [3:0]  s_sel;
  logic        s_we, s_cyc, s_stb;
  logic        s_ack;
  logic [31:0] s_rdat;
  logic [1:0]  grant;
  logic        slave_en;

  int checks = 0;
  int errors = 0;

  xfer_t q0[$];
  xfer_t q1[$];
  smp_t  trace[$];
  bit    rec = 1'b0;

  mem_wb_arbiter #(.TIMEOUT_CYCLES(4), .CNT_W(8)) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst_n),
    .m0_adr_i (madr[0]),
    .m0_dat_i (mdat[0]),
    .m0_sel_i (msel[0]),
    .m0_we_i  (mwe[0]),
    .m0_cyc_i (mcyc[0]),
    .m0_stb_i (mstb[0]),
    .m0_ack_o (m0_ack),
    .m0_err_o (m0_err),
    .m0_dat_o (m0_rdat),
    .m1_adr_i (madr[1]),
    .m1_dat_i (mdat[1]),
    .m1_sel_i (msel[1]),
    .m1_we_i  (mwe[1]),
    .m1_cyc_i (mcyc[1]),
    .m1_stb_i (mstb[1]),
    .m1_ack_o (m1_ack),
    .m1_err_o (m1_err),
    .m1_dat_o (m1_rdat),
    .s_adr_o  (s_adr),
    .s_dat_o  (s_dat),
    .s_sel_o  (s_sel),
    .s_we_o   (s_we),
    .s_cyc_o  (s_cyc),
    .s_stb_o  (s_stb),
    .s_ack_i  (s_ack),
    .s_dat_i  (s_rdat),
    .grant_o  (grant)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign s_rdat = RDATA;

  // Memory slave model: acks one cycle after it sees a strobe.
  always @(posedge clk) s_ack <= slave_en & s_cyc & s_stb & ~s_ack;

  // Per-cycle trace of grant/ack activity for the arbitration scenarios.
  always @(negedge clk) if (rec) trace.push_back({grant, m0_ack, m1_ack, mcyc[0]});

  // Slave-side scoreboard and ack routing checks.
  always @(negedge clk) begin
    xfer_t got;
    xfer_t exp;
    if (s_ack === 1'b1) begin
      checks++;
      if (m0_ack !== (grant == 2'b01) || m1_ack !== (grant == 2'b10)) begin
        errors++;
        $display("FAIL ack_route: grant=%b m0_ack=%b m1_ack=%b, ack required only on granted master",
                 grant, m0_ack, m1_ack);
      end
    end
    if (s_cyc && s_stb && s_ack) begin
      got = {s_adr, s_dat, s_sel, s_we};
      checks++;
      if (grant == 2'b01 && q0.size() > 0) begin
        exp = q0.pop_front();
        if (got !== exp) begin
          errors++;
          $display("FAIL sb_m0: got %h, required %h", got, exp);
        end
      end else if (grant == 2'b10 && q1.size() > 0) begin
        exp = q1.pop_front();
        if (got !== exp) begin
          errors++;
          $display("FAIL sb_m1: got %h, required %h", got, exp);
        end
      end else begin
        errors++;
        $display("FAIL sb_unexpected: transfer %h with grant=%b, required a queued transfer", got, grant);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation still running at 200000, required completion");
    $fatal(1, "global timeout");
  end

  function automatic xfer_t mk(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                               input logic w);
    xfer_t x;
    x.adr = a;
    x.dat = d;
    x.sel = s;
    x.we  = w;
    return x;
  endfunction

  // Collapse the trace into runs of grant values, skipping leading idle cycles.
  function automatic void grant_runs(output int n, output logic [1:0] v[8], output int l[8]);
    n = 0;
    for (int i = 0; i < 8; i++) begin
      v[i] = 2'b00;
      l[i] = 0;
    end
    foreach (trace[i]) begin
      if (n == 0 && trace[i].g == 2'b00) continue;
      if (n > 0 && v[n-1] == trace[i].g) l[n-1]++;
      else if (n < 8) begin
        v[n] = trace[i].g;
        l[n] = 1;
        n++;
      end
    end
  endfunction

  task automatic wait_grant(input logic [1:0] g, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (grant === g) ok = 1'b1;
    end
  endtask

  task automatic master_xfer(input int m, input logic [31:0] a, input logic we_v, input int beats);
    bit          got;
    logic [31:0] rd;
    @(posedge clk); #1;
    mcyc[m] = 1'b1;
    for (int b = 0; b < beats; b++) begin
      madr[m] = a + 32'(4 * b);
      mdat[m] = 32'hA500_0000 ^ a ^ 32'(b);
      msel[m] = 4'hF;
      mwe[m]  = we_v;
      mstb[m] = 1'b1;
      if (m == 0) q0.push_back(mk(madr[m], mdat[m], msel[m], we_v));
      else        q1.push_back(mk(madr[m], mdat[m], msel[m], we_v));
      got = 1'b0;
      for (int c = 0; c < 100 && !got; c++) begin
        @(negedge clk);
        got = (m == 0) ? m0_ack : m1_ack;
      end
      checks++;
      if (!got) begin
        errors++;
        $display("FAIL m%0d_ack_wait: ack=0 after 100 cycles, required 1", m);
      end else if (!we_v) begin
        rd = (m == 0) ? m0_rdat : m1_rdat;
        checks++;
        if (rd !== RDATA) begin
          errors++;
          $display("FAIL m%0d_rdata: got %h, required %h", m, rd, RDATA);
        end
      end
      @(posedge clk); #1;
      mstb[m] = 1'b0;
    end
    mcyc[m] = 1'b0;
    mwe[m]  = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n   = 1'b0;
    madr[0] = 32'hFFFF_FFFF; mdat[0] = 32'hFFFF_FFFF; msel[0] = 4'hF;
    mwe[0]  = 1'b1; mcyc[0] = 1'b1; mstb[0] = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({grant, s_cyc, s_stb, s_we, s_adr, s_dat, s_sel} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: grant=%b cyc=%b stb=%b we=%b adr=%h dat=%h sel=%h, required all 0",
               grant, s_cyc, s_stb, s_we, s_adr, s_dat, s_sel);
    end
    checks++;
    if ({m0_ack, m1_ack, m0_err, m1_err} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_resp: ack/err=%b, required 0000", {m0_ack, m1_ack, m0_err, m1_err});
    end
    mcyc[0] = 1'b0; mstb[0] = 1'b0; mwe[0] = 1'b0;
    madr[0] = '0; mdat[0] = '0; msel[0] = '0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_single_write();
    @(posedge clk); #1;
    madr[0] = 32'h0000_0010; mdat[0] = 32'hDEAD_BEEF; msel[0] = 4'hF;
    mwe[0]  = 1'b1; mcyc[0] = 1'b1; mstb[0] = 1'b1;
    q0.push_back(mk(32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 1'b1));
    @(negedge clk);
    checks++;
    if (grant !== 2'b00) begin
      errors++;
      $display("FAIL sw_latency: grant=%b in request cycle, required 00", grant);
    end
    @(negedge clk);
    checks++;
    if (grant !== 2'b01) begin
      errors++;
      $display("FAIL sw_grant: grant=%b, required 01", grant);
    end
    checks++;
    if ({s_cyc, s_stb, s_we, s_adr, s_dat, s_sel} !== {3'b111, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF}) begin
      errors++;
      $display("FAIL sw_mirror: cyc=%b stb=%b we=%b adr=%h dat=%h sel=%h, required 1 1 1 00000010 deadbeef f",
               s_cyc, s_stb, s_we, s_adr, s_dat, s_sel);
    end
    @(negedge clk);
    checks++;
    if (m0_ack !== 1'b1 || m1_ack !== 1'b0) begin
      errors++;
      $display("FAIL sw_ack: m0_ack=%b m1_ack=%b, required 1 0", m0_ack, m1_ack);
    end
    @(posedge clk); #1;
    mcyc[0] = 1'b0; mstb[0] = 1'b0; mwe[0] = 1'b0;
    @(negedge clk);
    checks++;
    if (m0_ack !== 1'b0) begin
      errors++;
      $display("FAIL sw_ack_pulse: m0_ack=%b after ack cycle, required 0", m0_ack);
    end
    @(negedge clk);
    checks++;
    if (grant !== 2'b00) begin
      errors++;
      $display("FAIL sw_release: grant=%b after cyc drop, required 00", grant);
    end
  endtask

  task automatic test_simultaneous();
    int         n;
    logic [1:0] v[8];
    int         l[8];
    do_reset();
    trace.delete();
    rec = 1'b1;
    fork
      master_xfer(0, 32'h0000_0100, 1'b1, 1);
      master_xfer(1, 32'h0000_0200, 1'b0, 1);
    join
    repeat (2) @(negedge clk);
    rec = 1'b0;
    grant_runs(n, v, l);
    checks++;
    if (n < 3 || v[0] !== 2'b01 || v[1] !== 2'b00 || l[1] != 1 || v[2] !== 2'b10) begin
      errors++;
      $display("FAIL sim_order: runs n=%0d %b/%0d %b/%0d %b/%0d, required 01 then 00x1 then 10",
               n, v[0], l[0], v[1], l[1], v[2], l[2]);
    end
  endtask

  task automatic test_burst_hold();
    int         n;
    int         acks01;
    bit         stolen;
    logic [1:0] v[8];
    int         l[8];
    trace.delete();
    rec = 1'b1;
    fork
      master_xfer(0, 32'h0000_0300, 1'b1, 3);
      begin
        repeat (3) @(posedge clk);
        master_xfer(1, 32'h0000_0400, 1'b0, 1);
      end
    join
    repeat (2) @(negedge clk);
    rec = 1'b0;
    acks01 = 0;
    stolen = 1'b0;
    foreach (trace[i]) begin
      if (trace[i].a0 && trace[i].g == 2'b01) acks01++;
      if (trace[i].c0 && trace[i].g == 2'b10) stolen = 1'b1;
    end
    checks++;
    if (acks01 != 3) begin
      errors++;
      $display("FAIL burst_acks: %0d m0 acks under grant 01, required 3", acks01);
    end
    checks++;
    if (stolen) begin
      errors++;
      $display("FAIL burst_split: m1 granted while m0_cyc_i=1, required no grant");
    end
    grant_runs(n, v, l);
    checks++;
    if (n < 3 || v[0] !== 2'b01 || v[1] !== 2'b00 || v[2] !== 2'b10) begin
      errors++;
      $display("FAIL burst_order: runs %b %b %b, required 01 00 10", v[0], v[1], v[2]);
    end
  endtask

  task automatic test_fairness();
    int         n;
    logic [1:0] v[8];
    int         l[8];
    bit         bad;
    trace.delete();
    rec = 1'b1;
    fork
      for (int k = 0; k < 2; k++) master_xfer(0, 32'h0000_0500 + 32'(k * 16), 1'b1, 1);
      for (int k = 0; k < 2; k++) master_xfer(1, 32'h0000_0600 + 32'(k * 16), 1'b0, 1);
    join
    repeat (2) @(negedge clk);
    rec = 1'b0;
    grant_runs(n, v, l);
    bad = (n < 7);
    for (int i = 0; i < 7; i++) begin
      if (i % 4 == 0 && v[i] !== 2'b01) bad = 1'b1;
      if (i % 4 == 2 && v[i] !== 2'b10) bad = 1'b1;
      if (i % 2 == 1 && (v[i] !== 2'b00 || l[i] != 1)) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL fair_order: runs %b %b %b %b %b %b %b, required 01 00 10 00 01 00 10",
               v[0], v[1], v[2], v[3], v[4], v[5], v[6]);
    end
  endtask

  task automatic test_timeout();
    bit ok;
    bit got;
    slave_en = 1'b0;
    @(posedge clk); #1;
    madr[1] = 32'h0000_0080; mdat[1] = '0; msel[1] = 4'hF;
    mwe[1]  = 1'b0; mcyc[1] = 1'b1; mstb[1] = 1'b1;
    wait_grant(2'b10, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL to_grant: grant=%b, required 10", grant);
    end
    for (int k = 1; k <= 4; k++) begin
      if (k > 1) @(negedge clk);
      checks++;
      if (m1_err !== (k == 4) || m0_err !== 1'b0) begin
        errors++;
        $display("FAIL to_err_cycle%0d: m1_err=%b m0_err=%b, required %b 0", k, m1_err, m0_err, (k == 4));
      end
      if (k == 1) begin
        madr[0] = 32'h0000_0040; mdat[0] = 32'hCAFE_F00D; msel[0] = 4'h3;
        mwe[0]  = 1'b1; mcyc[0] = 1'b1; mstb[0] = 1'b1;
        q0.push_back(mk(32'h0000_0040, 32'hCAFE_F00D, 4'h3, 1'b1));
      end
    end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks++;
      if (grant !== 2'b00 || s_cyc !== 1'b0 || s_stb !== 1'b0 || m1_err !== 1'b0) begin
        errors++;
        $display("FAIL to_errwait: grant=%b s_cyc=%b s_stb=%b m1_err=%b, required 00 0 0 0",
                 grant, s_cyc, s_stb, m1_err);
      end
    end
    @(posedge clk); #1;
    mcyc[1] = 1'b0; mstb[1] = 1'b0;
    slave_en = 1'b1;
    wait_grant(2'b01, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL to_regrant_m0: grant=%b, required 01", grant);
    end
    got = 1'b0;
    for (int c = 0; c < 20 && !got; c++) begin
      if (c > 0) @(negedge clk);
      got = m0_ack;
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL to_m0_ack: m0_ack=0 after 20 cycles, required 1");
    end
    @(posedge clk); #1;
    mcyc[0] = 1'b0; mstb[0] = 1'b0; mwe[0] = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_mid_transfer();
    bit         ok;
    int         n;
    logic [1:0] v[8];
    int         l[8];
    slave_en = 1'b1;
    @(posedge clk); #1;
    madr[1] = 32'h0000_0090; msel[1] = 4'hF;
    mwe[1]  = 1'b0; mcyc[1] = 1'b1; mstb[1] = 1'b1;
    wait_grant(2'b10, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL rm_grant: grant=%b, required 10", grant);
    end
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if (grant !== 2'b00 || s_cyc !== 1'b0) begin
      errors++;
      $display("FAIL rm_bus: grant=%b s_cyc=%b, required 00 0", grant, s_cyc);
    end
    checks++;
    if ({m0_ack, m1_ack, m0_err, m1_err} !== 4'b0000) begin
      errors++;
      $display("FAIL rm_resp: ack/err=%b, required 0000", {m0_ack, m1_ack, m0_err, m1_err});
    end
    @(posedge clk); #1;
    mcyc[1] = 1'b0; mstb[1] = 1'b0;
    rst_n = 1'b1;
    trace.delete();
    rec = 1'b1;
    fork
      master_xfer(0, 32'h0000_0700, 1'b1, 1);
      master_xfer(1, 32'h0000_0800, 1'b0, 1);
    join
    repeat (2) @(negedge clk);
    rec = 1'b0;
    grant_runs(n, v, l);
    checks++;
    if (n < 1 || v[0] !== 2'b01) begin
      errors++;
      $display("FAIL rm_tie: first grant=%b, required 01", v[0]);
    end
  endtask

  initial begin
    slave_en = 1'b1;
    for (int i = 0; i < 2; i++) begin
      madr[i] = '0; mdat[i] = '0; msel[i] = '0;
      mwe[i]  = 1'b0; mcyc[i] = 1'b0; mstb[i] = 1'b0;
    end
    test_reset();
    test_single_write();
    test_simultaneous();
    test_burst_hold();
    test_fairness();
    test_timeout();
    test_reset_mid_transfer();
    checks++;
    if (q0.size() != 0 || q1.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: %0d/%0d transfers never reached the slave, required 0/0", q0.size(), q1.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
